// File: rtl/systolic_skew_feeder_pkg.sv
// Shared definitions for the systolic skew feeder: default geometry, counter
// width and the controller state encoding.
package systolic_skew_feeder_pkg;

  localparam int LANES_DEF = 4;
  localparam int DW_DEF    = 32;
  localparam int CNT_W     = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    SWITCH,
    STREAM,
    DRAIN
  } state_e;

endpackage

// File: rtl/systolic_skew_feeder_skew.sv
// skew_lane: DEPTH-stage shift register that delays one activation lane.
// Every stage clears on reset so only zero bubbles can ever leave the pipe.
module skew_lane
  import systolic_skew_feeder_pkg::*;
#(
  parameter int DEPTH = 1,
  parameter int DW    = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] pipe_q [DEPTH];
  logic [DW-1:0] pipe_d [DEPTH];

  // NOTE: every output of a combinational block is assigned on every path, so no latch is inferred.
  always_comb begin
    pipe_d[0] = din;
    for (int i = 1; i < DEPTH; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // NOTE: the delay stages are reset on purpose; stale data would leak onto the array after an abort.
  // NOTE: state is written with non-blocking assignments so all stages shift on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Feeds a LANES x LANES systolic array: loads one weight row per beat onto
// b_out, pulses the weight switch, then streams activations skewed by lane.
module systolic_skew_feeder
  import systolic_skew_feeder_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [CNT_W-1:0]    num_vec,
  input  logic                w_valid,
  output logic                w_ready,
  input  logic [LANES*DW-1:0] w_data,
  input  logic                x_valid,
  output logic                x_ready,
  input  logic [LANES*DW-1:0] x_data,
  output logic [LANES*DW-1:0] a_out,
  output logic [LANES*DW-1:0] b_out,
  output logic                sw_out,
  output logic                busy,
  output logic                done
);

  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     num_vec_q, num_vec_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [LANES*DW-1:0]  b_q, b_d;
  logic                 w_ready_q, w_ready_d;
  logic                 x_ready_q, x_ready_d;
  logic                 sw_q, sw_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 w_acc, x_acc;
  logic [LANES*DW-1:0]  inject;

  assign w_acc = w_valid && w_ready_q;
  assign x_acc = x_valid && x_ready_q;

  // Cycles without an accepted vector push zeros, which the array treats as bubbles.
  assign inject = x_acc ? x_data : '0;

  // cnt_q counts weight beats in LOAD_W, vectors in STREAM and cycles in DRAIN.
  always_comb begin
    state_d   = state_q;
    num_vec_d = num_vec_q;
    cnt_d     = cnt_q;
    b_d       = b_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = LOAD_W;
          num_vec_d = num_vec;
          cnt_d     = '0;
        end
      end
      LOAD_W: begin
        if (w_acc) begin
          b_d = w_data;
          if (cnt_q == LAST_LANE) begin
            state_d = SWITCH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      SWITCH: begin
        state_d = (num_vec_q == '0) ? DRAIN : STREAM;
        cnt_d   = '0;
      end
      STREAM: begin
        if (x_acc) begin
          if (cnt_q + 1'b1 == num_vec_q) begin
            state_d = DRAIN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (cnt_q == LAST_LANE) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Handshake and status flags are decoded from the next state so they line up with state_q.
    w_ready_d = (state_d == LOAD_W);
    x_ready_d = (state_d == STREAM);
    sw_d      = (state_d == SWITCH);
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      num_vec_q <= '0;
      cnt_q     <= '0;
      b_q       <= '0;
      w_ready_q <= 1'b0;
      x_ready_q <= 1'b0;
      sw_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      num_vec_q <= num_vec_d;
      cnt_q     <= cnt_d;
      b_q       <= b_d;
      w_ready_q <= w_ready_d;
      x_ready_q <= x_ready_d;
      sw_q      <= sw_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    skew_lane #(
      .DEPTH(k + 1),
      .DW   (DW)
    ) u_skew_lane (
      .clk (clk),
      .rst (rst),
      .din (inject[k*DW +: DW]),
      .dout(a_out[k*DW +: DW])
    );
  end

  assign b_out   = b_q;
  assign w_ready = w_ready_q;
  assign x_ready = x_ready_q;
  assign sw_out  = sw_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder: weight load, skew timing, stalls,
// empty jobs, start while busy and mid-job reset.
module tb_systolic_skew_feeder;

  localparam int LANES = 4;
  localparam int DW    = 32;
  localparam int W     = LANES * DW;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [7:0]   num_vec;
  logic         w_valid, w_ready;
  logic [W-1:0] w_data;
  logic         x_valid, x_ready;
  logic [W-1:0] x_data;
  logic [W-1:0] a_out, b_out;
  logic         sw_out, busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  systolic_skew_feeder #(.LANES(LANES), .DW(DW)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .num_vec(num_vec),
    .w_valid(w_valid),
    .w_ready(w_ready),
    .w_data (w_data),
    .x_valid(x_valid),
    .x_ready(x_ready),
    .x_data (x_data),
    .a_out  (a_out),
    .b_out  (b_out),
    .sw_out (sw_out),
    .busy   (busy),
    .done   (done)
  );

  // Outputs are sampled 1 ns after the rising edge; inputs change at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_rows();
    for (int i = 0; i < LANES; i++) begin
      w_valid = 1'b1;
      w_data  = {LANES{DW'(32'hA0 + i)}};
      tick();
    end
    w_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int k = 0;
    while (done !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: done not seen within %0d cycles (got %b want 1)", name, budget, done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; num_vec = '0;
    w_valid = 1'b0; w_data = '0; x_valid = 1'b0; x_data = '0;
    tick();
    tick();
    n_checks++;
    if ({a_out, b_out} !== '0) begin
      n_fail++; $display("FAIL reset_data: got a=%h b=%h want 0", a_out, b_out);
    end
    n_checks++;
    if ({busy, done, sw_out, w_ready, x_ready} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got busy/done/sw/wr/xr=%b want 00000",
               {busy, done, sw_out, w_ready, x_ready});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_weight_load();
    logic [DW-1:0] r;
    logic [W-1:0]  row;
    start = 1'b1; num_vec = 8'd1;
    tick();
    start = 1'b0;
    n_checks++;
    if ({busy, w_ready, x_ready} !== 3'b110) begin
      n_fail++; $display("FAIL load_enter: got busy/wr/xr=%b want 110", {busy, w_ready, x_ready});
    end
    for (int i = 0; i < LANES; i++) begin
      r       = DW'(32'h11 * (i + 1));
      row     = {LANES{r}};
      w_data  = row;
      w_valid = 1'b1;
      tick();
      n_checks++;
      if (b_out !== row) begin
        n_fail++; $display("FAIL load_b_out beat %0d: got %h want %h", i, b_out, row);
      end
      n_checks++;
      if (sw_out !== (i == LANES - 1)) begin
        n_fail++; $display("FAIL load_sw beat %0d: got %b want %b", i, sw_out, (i == LANES - 1));
      end
    end
    w_valid = 1'b0;
    n_checks++;
    if ({w_ready, x_ready} !== 2'b00) begin
      n_fail++; $display("FAIL switch_ready: got wr/xr=%b want 00", {w_ready, x_ready});
    end
    tick();
    n_checks++;
    if ({sw_out, x_ready} !== 2'b01) begin
      n_fail++; $display("FAIL stream_enter: got sw/xr=%b want 01", {sw_out, x_ready});
    end
    x_data  = {LANES{32'h5}};
    x_valid = 1'b1;
    tick();
    x_valid = 1'b0;
    wait_done("load_done", 10);
    n_checks++;
    if (b_out !== {LANES{32'h44}}) begin
      n_fail++; $display("FAIL load_b_hold: got %h want %h", b_out, {LANES{32'h44}});
    end
    tick();
  endtask

  task automatic test_skew();
    logic [W-1:0] exp;
    start = 1'b1; num_vec = 8'd1;
    tick();
    start = 1'b0;
    load_rows();
    tick();
    x_data  = {32'd4, 32'd3, 32'd2, 32'd1};
    x_valid = 1'b1;
    tick();
    x_valid = 1'b0;
    for (int t = 1; t <= LANES + 2; t++) begin
      exp = '0;
      if (t <= LANES) exp[(t-1)*DW +: DW] = DW'(t);
      n_checks++;
      if (a_out !== exp) begin
        n_fail++; $display("FAIL skew_a_out t=%0d: got %h want %h", t, a_out, exp);
      end
      n_checks++;
      if ({done, busy, x_ready} !== {(t == LANES + 1), (t <= LANES), 1'b0}) begin
        n_fail++;
        $display("FAIL skew_flags t=%0d: got done/busy/xr=%b want %b", t,
                 {done, busy, x_ready}, {(t == LANES + 1), (t <= LANES), 1'b0});
      end
      tick();
    end
  endtask

  task automatic test_stall();
    logic [4:0]    pat = 5'b10101;
    logic [W-1:0]  vec [3];
    logic [W-1:0]  inj [5];
    logic [W-1:0]  exp;
    int            src;
    int            n_done = 0;
    for (int m = 0; m < 3; m++)
      for (int k = 0; k < LANES; k++)
        vec[m][k*DW +: DW] = DW'(32'h100 * (m + 1) + k);
    for (int j = 0; j < 5; j++) inj[j] = pat[j] ? vec[j/2] : '0;

    start = 1'b1; num_vec = 8'd3;
    tick();
    start = 1'b0;
    load_rows();
    tick();
    for (int j = 0; j < 11; j++) begin
      x_valid = (j < 5) && pat[j];
      x_data  = x_valid ? vec[j/2] : {LANES{32'hDEAD_BEEF}};
      tick();
      exp = '0;
      for (int k = 0; k < LANES; k++) begin
        src = j - k;
        if (src >= 0 && src < 5) exp[k*DW +: DW] = inj[src][k*DW +: DW];
      end
      if (done === 1'b1) n_done++;
      n_checks++;
      if (a_out !== exp) begin
        n_fail++; $display("FAIL stall_a_out t=%0d: got %h want %h", j + 1, a_out, exp);
      end
      n_checks++;
      if ({done, busy, x_ready} !== {(j + 1 == 9), (j + 1 < 9), (j + 1 < 5)}) begin
        n_fail++;
        $display("FAIL stall_flags t=%0d: got done/busy/xr=%b want %b", j + 1,
                 {done, busy, x_ready}, {(j + 1 == 9), (j + 1 < 9), (j + 1 < 5)});
      end
    end
    x_valid = 1'b0;
    n_checks++;
    if (n_done != 1) begin
      n_fail++; $display("FAIL stall_done_count: got %0d want 1", n_done);
    end
  endtask

  task automatic test_zero_vec();
    int n_done = 0;
    start = 1'b1; num_vec = 8'd0;
    tick();
    start = 1'b0;
    load_rows();
    n_checks++;
    if ({sw_out, x_ready, w_ready} !== 3'b100) begin
      n_fail++; $display("FAIL zero_switch: got sw/xr/wr=%b want 100", {sw_out, x_ready, w_ready});
    end
    x_valid = 1'b1;
    x_data  = {LANES{32'h77}};
    for (int t = 1; t <= 6; t++) begin
      tick();
      if (done === 1'b1) n_done++;
      n_checks++;
      if ({x_ready, sw_out, busy, done} !== {1'b0, 1'b0, (t <= 4), (t == 5)}) begin
        n_fail++;
        $display("FAIL zero_flags t=%0d: got xr/sw/busy/done=%b want %b", t,
                 {x_ready, sw_out, busy, done}, {1'b0, 1'b0, (t <= 4), (t == 5)});
      end
      n_checks++;
      if (a_out !== '0) begin
        n_fail++; $display("FAIL zero_a_out t=%0d: got %h want 0", t, a_out);
      end
    end
    x_valid = 1'b0;
    n_checks++;
    if (n_done != 1) begin
      n_fail++; $display("FAIL zero_done_count: got %0d want 1", n_done);
    end
  endtask

  task automatic test_start_held();
    start = 1'b1; num_vec = 8'd1;
    tick();
    load_rows();
    n_checks++;
    if ({sw_out, busy} !== 2'b11) begin
      n_fail++; $display("FAIL held_switch: got sw/busy=%b want 11", {sw_out, busy});
    end
    tick();
    x_data  = {LANES{32'h9}};
    x_valid = 1'b1;
    tick();
    x_valid = 1'b0;
    n_checks++;
    if (x_ready !== 1'b0) begin
      n_fail++; $display("FAIL held_drain: got xr=%b want 0", x_ready);
    end
    wait_done("held_done", 10);
    num_vec = 8'd5;
    tick();
    start = 1'b0;
    n_checks++;
    if ({busy, w_ready, done} !== 3'b110) begin
      n_fail++; $display("FAIL held_restart: got busy/wr/done=%b want 110", {busy, w_ready, done});
    end
  endtask

  task automatic test_reset_mid();
    load_rows();
    tick();
    x_data  = {LANES{32'h3C}};
    x_valid = 1'b1;
    tick();
    n_checks++;
    if ({busy, x_ready} !== 2'b11) begin
      n_fail++; $display("FAIL mid_pre: got busy/xr=%b want 11", {busy, x_ready});
    end
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    x_valid = 1'b0;
    n_checks++;
    if ({a_out, b_out} !== '0) begin
      n_fail++; $display("FAIL mid_data: got a=%h b=%h want 0", a_out, b_out);
    end
    n_checks++;
    if ({busy, done, x_ready, w_ready, sw_out} !== 5'b0) begin
      n_fail++;
      $display("FAIL mid_flags: got busy/done/xr/wr/sw=%b want 00000",
               {busy, done, x_ready, w_ready, sw_out});
    end
    for (int t = 1; t <= 5; t++) begin
      tick();
      n_checks++;
      if ({a_out, busy, done} !== '0) begin
        n_fail++;
        $display("FAIL mid_after t=%0d: got a=%h busy=%b done=%b want 0", t, a_out, busy, done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_weight_load();
    test_skew();
    test_stall();
    test_zero_vec();
    test_start_held();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_skew_feeder.md
SYSTOLIC_SKEW_FEEDER -- requirements
Module: systolic_skew_feeder

Interface
REQ-001 Parameter: LANES, default 4, number of array rows/columns fed.
REQ-002 Parameter: DW, default 32, element width in bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  one-cycle request to begin a job; sampled only in IDLE.
REQ-006 num_vec  input  8  count of activation vectors in the job; sampled with start.
REQ-007 w_valid / w_ready  input / output  1 each  weight-row handshake.
REQ-008 w_data  input  LANES*DW  one weight row, lane k at bits [k*DW +: DW].
REQ-009 x_valid / x_ready  input / output  1 each  activation-vector handshake.
REQ-010 x_data  input  LANES*DW  one activation vector, lane k at bits [k*DW +: DW].
REQ-011 a_out  output  LANES*DW  skewed activations to the array's a inputs.
REQ-012 b_out  output  LANES*DW  weight row to the array's b inputs.
REQ-013 sw_out  output  1  weight-commit pulse to the array's switch input.
REQ-014 busy  output  1  high whenever state is not IDLE.
REQ-015 done  output  1  one-cycle pulse at job end.

Function
REQ-016 FSM states: IDLE, LOAD_W, SWITCH, STREAM, DRAIN.
REQ-017 IDLE -> LOAD_W on start; num_vec latched; start outside IDLE ignored.
REQ-018 LOAD_W: w_ready=1; each w_valid&&w_ready transfer registers w_data onto b_out the next cycle; b_out holds its value between beats.
REQ-019 LOAD_W -> SWITCH after exactly LANES accepted weight beats; no stall limit.
REQ-020 SWITCH: one cycle, sw_out=1, w_ready=0, x_ready=0; next state STREAM, or DRAIN if latched num_vec==0.
REQ-021 STREAM: x_ready=1; accepted-vector counter increments per x_valid&&x_ready transfer.
REQ-022 Skew: lane k of an accepted vector appears on a_out lane k exactly k+1 cycles after the accept edge (lane 0 latency 1, lane LANES-1 latency LANES).
REQ-023 Any STREAM/DRAIN cycle with no accept injects zero into every lane's skew pipe (bubble); bubbles are skewed like data.
REQ-024 STREAM -> DRAIN on the accept edge of beat num_vec; x_ready deasserts the following cycle.
REQ-025 DRAIN: lasts exactly LANES cycles, injecting zeros, so the last vector's lane LANES-1 reaches a_out.
REQ-026 DRAIN end: done=1 for one cycle, state -> IDLE; b_out keeps last weight row.
REQ-027 sw_out and done never high together; w_ready and x_ready never high together.
REQ-028 Lanes are pass-through: no arithmetic; num_vec counter 8-bit, compares to latched value, no wrap (max 255).

Reset
REQ-029 rst (synchronous) forces state IDLE, all skew registers, a_out, b_out to 0, counters to 0, sw_out/busy/done/w_ready/x_ready to 0 on the same edge.
REQ-030 rst mid-job aborts with no done pulse; rst has priority over start and all handshakes.

Structure
REQ-031 Shared package holds LANES, DW defaults and the FSM state enum.
REQ-032 One sub-module: skew_lane (parameter DEPTH, DW), a DEPTH-stage zero-reset shift register; instantiated LANES times with DEPTH=k+1.

Verification
REQ-033 Reset: assert rst 2 cycles mid-STREAM -> next cycle a_out=0, b_out=0, busy=0, no done.
REQ-034 Weight load: start, weights rows 0x11,0x22,0x33,0x44 (all lanes) back-to-back -> b_out shows each one cycle later, sw_out=1 exactly one cycle after 4th beat.
REQ-035 Skew: num_vec=1, x_data lanes {4,3,2,1} (lane0=1) -> a_out lane0=1 at +1, lane1=2 at +2, lane2=3 at +3, lane3=4 at +4; zeros otherwise; done at DRAIN end.
REQ-036 Stall: num_vec=3, x_valid gapped 1-0-1-0-1 -> zero bubbles between vectors on every lane, done once, busy falls with done.
REQ-037 num_vec=0 -> SWITCH then DRAIN of 4 cycles, x_ready never high, done once.
REQ-038 start held high while busy -> no restart; after done, new start begins LOAD_W next cycle.
